// File: rtl/led_matrix_scan.sv
// led_matrix_scan
//   Row scanner for an 8x8 LED matrix. At each frame start it takes a
//   snapshot of the eight row bitmaps. Each row slot is CLK_DIV cycles
//   long: BLANK_CYCLES dark cycles, then the row drive. Outputs that are
//   inactive use the configured polarity.
//
//   Ports
//     clk, rst_n            clock; reset is synchronous and active-low
//     en                    scan enable (0 = idle, display dark)
//     row_1..row_8 [7:0]    row bitmaps; bit j lights column j
//     dim_level [2:0]       brightness (only when MATRIX_DIM_EN is defined)
//     row_sel [7:0]         row strobe (bit k = row k+1)
//     col_drv [7:0]         column data for the selected row
//     scan_idx [2:0]        index of the row being blanked or driven
//     frame_start           1-cycle pulse in the first cycle of row 0
//
//   Optional feature macro: MATRIX_DIM_EN. It adds dim_level, which
//   shortens the column on-time inside DRIVE.
module led_matrix_scan #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int ROW_ACT_LOW  = 0,
  parameter int COL_ACT_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] row_1,
  input  logic [7:0] row_2,
  input  logic [7:0] row_3,
  input  logic [7:0] row_4,
  input  logic [7:0] row_5,
  input  logic [7:0] row_6,
  input  logic [7:0] row_7,
  input  logic [7:0] row_8,
`ifdef MATRIX_DIM_EN
  input  logic [2:0] dim_level,
`endif
  output logic [7:0] row_sel,
  output logic [7:0] col_drv,
  output logic [2:0] scan_idx,
  output logic       frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_FIRST = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST   = CW'(CLK_DIV - 1);
  // Inactive levels. XOR with these applies the polarity to active data.
  localparam logic [7:0] ROW_OFF = (ROW_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0] COL_OFF = (COL_ACT_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0][7:0] snap_q, snap_d;
  logic [7:0][7:0] rows_in;
  logic [7:0]      row_sel_q, row_sel_d;
  logic [7:0]      col_drv_q, col_drv_d;
  logic            fs_q, fs_d;
  logic            load;       // snapshot capture / frame start on this edge
  logic            col_on;
`ifdef MATRIX_DIM_EN
  logic [2:0]      dim_q, dim_d;
  localparam int unsigned D = CLK_DIV - BLANK_CYCLES;
  logic [31:0]     dim_lim, drv_off;
`endif

  assign rows_in = {row_8, row_7, row_6, row_5, row_4, row_3, row_2, row_1};

  // State register. Reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      row_sel_q <= ROW_OFF;
      col_drv_q <= COL_OFF;
      fs_q      <= 1'b0;
`ifdef MATRIX_DIM_EN
      dim_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      row_sel_q <= row_sel_d;
      col_drv_q <= col_drv_d;
      fs_q      <= fs_d;
`ifdef MATRIX_DIM_EN
      dim_q     <= dim_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load    = 1'b0;
    if (!en) begin
      // A later enable restarts the scan from row 0, so no position is kept.
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          load    = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = DRIVE_FIRST;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;   // 7 wraps to 0
            load    = (idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
    snap_d = load ? rows_in : snap_q;
`ifdef MATRIX_DIM_EN
    dim_d  = load ? dim_level : dim_q;
`endif
  end

  // Output logic. Outputs are computed from the next state, so the
  // registered outputs stay aligned with the registered state.
  always_comb begin
    row_sel_d = ROW_OFF;
    col_drv_d = COL_OFF;
    fs_d      = load;
    col_on    = 1'b1;
`ifdef MATRIX_DIM_EN
    // The columns are lit for the first (D*(dim+1))/8 cycles of DRIVE.
    dim_lim = (32'(D) * (32'(dim_d) + 32'd1)) / 32'd8;
    drv_off = 32'(cnt_d) - 32'(BLANK_CYCLES);
    col_on  = (drv_off < dim_lim);
`endif
    if (state_d == DRIVE) begin
      row_sel_d = (8'd1 << idx_d) ^ ROW_OFF;
      if (col_on) col_drv_d = snap_d[idx_d] ^ COL_OFF;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_drv     = col_drv_q;
  assign scan_idx    = idx_q;
  assign frame_start = fs_q;

endmodule
